// File: rtl/sfifo_rd_stage.sv
// Read-side stage for the flop-based synchronous FIFO: pops the FIFO head into a
// 2-entry output buffer that drives a registered valid/ready stream, with flush and a saturating delivered-word counter.
module sfifo_rd_stage #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [WIDTH-1:0]    fifo_dout,
    output logic                fifo_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    input  logic                flush,
    output logic [1:0]          occ,
    output logic [CNT_BITS-1:0] word_cnt
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]          occ_q;
    logic [WIDTH-1:0]    head_q;
    logic [WIDTH-1:0]    skid_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                pop;
    logic                take;

    // A pop this cycle frees a slot, so a full buffer can still take a word.
    assign out_valid = (occ_q != OCC_EMPTY);
    assign pop       = out_valid & out_ready;
    assign take      = !rst & !fifo_empty & !flush & ((occ_q < OCC_FULL) | pop);

    assign fifo_rd  = take;
    assign out_data = head_q;
    assign occ      = occ_q;
    assign word_cnt = cnt_q;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours (head <- skid while skid <- word).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (pop && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (flush) begin
                occ_q <= OCC_EMPTY;
            end else begin
                case (occ_q)
                    OCC_EMPTY: begin
                        if (take) begin
                            head_q <= fifo_dout;
                            occ_q  <= OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (take && pop) begin
                            head_q <= fifo_dout;
                        end else if (take) begin
                            skid_q <= fifo_dout;
                            occ_q  <= OCC_FULL;
                        end else if (pop) begin
                            occ_q <= OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        if (pop) begin
                            head_q <= skid_q;
                            if (take) begin
                                skid_q <= fifo_dout;
                            end else begin
                                occ_q <= OCC_ONE;
                            end
                        end
                    end
                    default: occ_q <= OCC_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sfifo_rd_stage.sv
// Directed bench for sfifo_rd_stage: a queue stands in for the FIFO and a
// scoreboard of popped-but-undelivered words checks order, occupancy and counters.
module tb_sfifo_rd_stage;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [15:0] fifo_dout;
    logic        fifo_rd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        flush;
    logic [1:0]  occ;
    logic [15:0] word_cnt;

    logic        fifo_rd4;
    logic        out_valid4;
    logic [15:0] out_data4;
    logic [1:0]  occ4;
    logic [3:0]  word_cnt4;

    logic [15:0] fifo_q[$];
    logic [15:0] sent_q[$];
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;
    logic        last_rd;
    int          n_vec;
    int          n_err;

    sfifo_rd_stage #(.WIDTH(16), .CNT_BITS(16)) u_dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .occ(occ), .word_cnt(word_cnt)
    );

    // Same stimulus into a narrow-counter copy to exercise saturation.
    sfifo_rd_stage #(.WIDTH(16), .CNT_BITS(4)) u_dut4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .flush(flush), .occ(occ4), .word_cnt(word_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic upd_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
    endtask

    task automatic push_words(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + 16'(i));
        upd_fifo();
    endtask

    // One clock: sample handshakes before the edge, advance the models after it.
    task automatic cycle();
        logic        rd_s, pop_s, fl_s;
        logic [15:0] d_s, dout_s;
        #1;
        rd_s   = fifo_rd;
        pop_s  = out_valid && out_ready;
        fl_s   = flush;
        d_s    = out_data;
        dout_s = fifo_dout;
        @(posedge clk);
        #1;
        last_rd = rd_s;
        if (pop_s) begin
            n_vec++;
            if (sent_q.size() == 0) begin
                n_err++;
                $display("FAIL order: delivered %h but no word was outstanding", d_s);
            end else begin
                if (d_s !== sent_q[0]) begin
                    n_err++;
                    $display("FAIL order: delivered %h expected %h", d_s, sent_q[0]);
                end
                void'(sent_q.pop_front());
            end
            if (exp_cnt != 16'hFFFF) exp_cnt++;
            if (exp_cnt4 != 4'hF) exp_cnt4++;
        end
        if (fl_s) sent_q.delete();
        if (rd_s) begin
            void'(fifo_q.pop_front());
            sent_q.push_back(dout_s);
        end
        upd_fifo();
        n_vec++;
        if (occ !== 2'(sent_q.size()) || out_valid !== (sent_q.size() != 0)) begin
            n_err++;
            $display("FAIL occ: got occ=%0d valid=%b expected occ=%0d", occ, out_valid, sent_q.size());
        end
        n_vec++;
        if (word_cnt !== exp_cnt || word_cnt4 !== exp_cnt4) begin
            n_err++;
            $display("FAIL word_cnt: got %h/%h expected %h/%h", word_cnt, word_cnt4, exp_cnt, exp_cnt4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #1;
        push_words(16'h0001, 5);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== 16'h0 || word_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b occ=%0d data=%h cnt=%h expected 0", out_valid, occ, out_data, word_cnt);
        end
        n_vec++;
        if (fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rd: got fifo_rd=%b expected 0", fifo_rd);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (occ !== 2'd0 || fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got occ=%0d rd=%b expected 0/0", occ, fifo_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_vec++;
            if (last_rd !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'(i + 1)) begin
                n_err++;
                $display("FAIL stream_%0d: got rd=%b valid=%b data=%h expected 1/1/%h", i, last_rd, out_valid, out_data, 16'(i + 1));
            end
        end
        cycle();
        n_vec++;
        if (last_rd !== 1'b0 || word_cnt !== 16'd5 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL stream_end: got rd=%b cnt=%0d occ=%0d expected 0/5/0", last_rd, word_cnt, occ);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_words(16'h0010, 4);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_vec++;
            if (last_rd !== (i < 2) || out_data !== 16'h0010) begin
                n_err++;
                $display("FAIL bp_%0d: got rd=%b data=%h expected %b/0010", i, last_rd, out_data, (i < 2));
            end
        end
        n_vec++;
        if (occ !== 2'd2 || fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got occ=%0d rd=%b expected 2/0", occ, fifo_rd);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_vec++;
            if (out_valid !== (i < 3) || (i < 3 && out_data !== 16'h0011 + 16'(i))) begin
                n_err++;
                $display("FAIL bp_drain_%0d: got valid=%b data=%h expected %b/%h", i, out_valid, out_data, (i < 3), 16'h0011 + 16'(i));
            end
        end
        n_vec++;
        if (word_cnt !== 16'd9) begin
            n_err++;
            $display("FAIL bp_cnt: got %0d expected 9", word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        push_words(16'h0020, 8);
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sent_q.size() != 0 || fifo_q.size() != 0); i++) cycle();
        n_vec++;
        if (word_cnt !== 16'd17 || occ !== 2'd0 || fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL toggle_end: got cnt=%0d occ=%0d empty=%b expected 17/0/1", word_cnt, occ, fifo_empty);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_words(16'h0030, 5);
        for (int i = 0; i < 3; i++) cycle();
        flush = 1'b1;
        #1;
        n_vec++;
        if (occ !== 2'd2 || fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL flush_rd: got occ=%0d rd=%b expected 2/0", occ, fifo_rd);
        end
        cycle();
        flush = 1'b0;
        n_vec++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || fifo_q.size() != 3) begin
            n_err++;
            $display("FAIL flush_clear: got occ=%0d valid=%b fifo_left=%0d expected 0/0/3", occ, out_valid, fifo_q.size());
        end
        out_ready = 1'b1;
        cycle();
        n_vec++;
        if (out_data !== 16'h0032) begin
            n_err++;
            $display("FAIL flush_next: got %h expected 0032", out_data);
        end
        for (int i = 0; i < 3; i++) cycle();
        n_vec++;
        if (word_cnt !== 16'd20) begin
            n_err++;
            $display("FAIL flush_cnt: got %0d expected 20", word_cnt);
        end
    endtask

    task automatic test_flush_pop();
        out_ready = 1'b1;
        push_words(16'h0040, 2);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n_vec++;
        if (word_cnt !== 16'd21 || occ !== 2'd0) begin
            n_err++;
            $display("FAIL flush_pop: got cnt=%0d occ=%0d expected 21/0", word_cnt, occ);
        end
        cycle();
        cycle();
        n_vec++;
        if (word_cnt !== 16'd22 || word_cnt4 !== 4'hF) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d cnt4=%h expected 22/f", word_cnt, word_cnt4);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push_words(16'h0050, 3);
        cycle();
        cycle();
        n_vec++;
        if (occ !== 2'd2) begin
            n_err++;
            $display("FAIL ar_setup: got occ=%0d expected 2", occ);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || word_cnt !== 16'd0 || word_cnt4 !== 4'd0 || fifo_rd !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b occ=%0d cnt=%h rd=%b expected all 0", out_valid, occ, word_cnt, fifo_rd);
        end
        fifo_q.delete();
        sent_q.delete();
        exp_cnt = '0;
        exp_cnt4 = '0;
        upd_fifo();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_cnt = '0; exp_cnt4 = '0; last_rd = 1'b0;
        rst = 1'b1; out_ready = 1'b0; flush = 1'b0;
        upd_fifo();
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_flush_pop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
